// File: rtl/wb_pkg.sv
// wb_pkg: shared entry type, default widths and the round-robin pick helper
// used by the write-back commit unit and its per-channel FIFOs.
package wb_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int REG_AW_DEF = 5;
  localparam int MAX_CH     = 8;

  typedef struct packed {
    logic                  wen;
    logic [REG_AW_DEF-1:0] dest;
    logic [XLEN_DEF-1:0]   data;
  } wb_entry_t;

  // First requester at or after ptr, scanning upward and wrapping at n channels.
  function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [2:0]        ptr,
                                         input logic [3:0]        n);
    logic [3:0] idx;
    logic       found;
    rr_pick = '0;
    found   = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= n) idx = idx - n;
      if (!found && (4'(i) < n) && req[idx[2:0]]) begin
        rr_pick = idx[2:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/writeback_commit_unit_fifo.sv
// wb_chan_fifo: one channel's circular buffer of packed write-back entries.
// DEPTH must be a power of two so the pointers wrap on their own.
module wb_chan_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = $bits(wb_entry_t)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/writeback_commit_unit.sv
// writeback_commit_unit: per-channel result FIFOs arbitrated round-robin onto one
// register-file write port. Define WB_PERF_CNT_EN to add retire/stall counters.
module writeback_commit_unit
  import wb_pkg::*;
#(
  parameter int  NUM_CH     = 2,
  parameter int  XLEN       = XLEN_DEF,
  parameter int  REG_AW     = REG_AW_DEF,
  parameter int  FIFO_DEPTH = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH-1:0]        in_wen,
  input  logic [NUM_CH*REG_AW-1:0] in_dest,
  input  logic [NUM_CH*XLEN-1:0]   in_data,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  output logic                     wb_done,
  output logic [CH_W-1:0]          wb_ch,
  output logic                     busy
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]              perf_retired,
  output logic [NUM_CH*32-1:0]     perf_stall
`endif
);

  typedef struct packed {
    logic              wen;
    logic [REG_AW-1:0] dest;
    logic [XLEN-1:0]   data;
  } entry_t;

  localparam int EW    = $bits(entry_t);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0] push, pop, full, empty, nonzero;
  logic [EW-1:0]     push_entry [NUM_CH];
  logic [EW-1:0]     pop_entry  [NUM_CH];
  logic [CNT_W-1:0]  count      [NUM_CH];

  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d, grant;
  logic [MAX_CH-1:0] req;
  logic              any_req;
  entry_t            sel;

  logic              rf_we_q, rf_we_d, wb_done_q, wb_done_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic [CH_W-1:0]   wb_ch_q, wb_ch_d;

  // Ready is held low during reset so nothing is offered a slot that reset will clear.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign push_entry[i] = {in_wen[i], in_dest[i*REG_AW +: REG_AW], in_data[i*XLEN +: XLEN]};
    assign in_ready[i]   = !full[i] && !reset;
    assign push[i]       = in_valid[i] && in_ready[i];
    assign pop[i]        = any_req && (grant == CH_W'(i));
    assign nonzero[i]    = (count[i] != '0);

    wb_chan_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[i]),
      .push_data (push_entry[i]),
      .pop       (pop[i]),
      .pop_data  (pop_entry[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .count     (count[i])
    );
  end

  always_comb begin
    req                = '0;
    req[NUM_CH-1:0]    = ~empty;
    any_req            = |req;
    grant              = CH_W'(rr_pick(req, 3'(rr_ptr_q), 4'(NUM_CH)));
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_req) rr_ptr_d = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
  end

  // Address/data/channel hold between pops; x0 writes retire without a write strobe.
  always_comb begin
    sel        = entry_t'(pop_entry[grant]);
    wb_done_d  = any_req;
    rf_we_d    = any_req && sel.wen && (sel.dest != '0);
    rf_waddr_d = any_req ? sel.dest : rf_waddr_q;
    rf_wdata_d = any_req ? sel.data : rf_wdata_q;
    wb_ch_d    = any_req ? grant    : wb_ch_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      wb_done_q  <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_ch_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      wb_done_q  <= wb_done_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_ch_q    <= wb_ch_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign wb_done  = wb_done_q;
  assign wb_ch    = wb_ch_q;
  assign busy     = (|nonzero) || wb_done_q;

`ifdef WB_PERF_CNT_EN
  logic [31:0]          perf_retired_q;
  logic [NUM_CH*32-1:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (wb_done_q) perf_retired_q <= perf_retired_q + 32'd1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_valid[i] && !in_ready[i])
          perf_stall_q[i*32 +: 32] <= perf_stall_q[i*32 +: 32] + 32'd1;
      end
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_writeback_commit_unit.sv
// tb_writeback_commit_unit: directed self-checking bench for the default
// configuration (NUM_CH=2, XLEN=64, REG_AW=5, FIFO_DEPTH=2).
module tb_writeback_commit_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   in_valid, in_ready, in_wen;
  logic [9:0]   in_dest;
  logic [127:0] in_data;
  logic         rf_we, wb_done, busy;
  logic [4:0]   rf_waddr;
  logic [63:0]  rf_wdata;
  logic [0:0]   wb_ch;
`ifdef WB_PERF_CNT_EN
  logic [31:0]  perf_retired;
  logic [63:0]  perf_stall;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  writeback_commit_unit #(
    .NUM_CH(2), .XLEN(64), .REG_AW(5), .FIFO_DEPTH(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_wen   (in_wen),
    .in_dest  (in_dest),
    .in_data  (in_data),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .wb_done  (wb_done),
    .wb_ch    (wb_ch),
    .busy     (busy)
`ifdef WB_PERF_CNT_EN
    ,
    .perf_retired (perf_retired),
    .perf_stall   (perf_stall)
`endif
  );

  function automatic logic [63:0] dat(input int c, input int k);
    return {4'hA + 4'(c), 52'd0, 8'(k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input logic v, input logic w,
                       input logic [4:0] d, input logic [63:0] x);
    in_valid[c]          = v;
    in_wen[c]            = w;
    in_dest[c*5 +: 5]    = d;
    in_data[c*64 +: 64]  = x;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 5'd0, 64'h11);
    drive(1, 1'b1, 1'b0, 5'd0, 64'h22);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b want 00", in_ready); end
      checks++;
      if ({rf_we, wb_done, wb_ch, rf_waddr, busy} !== 9'd0 || rf_wdata !== 64'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: we=%b done=%b ch=%b addr=%0d data=%h busy=%b want all 0",
                 rf_we, wb_done, wb_ch, rf_waddr, rf_wdata, busy);
      end
    end
    reset = 1'b0;
    tick();
    in_valid = 2'b00;
    checks++;
    if (wb_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_release1: done=%b busy=%b want 0 1", wb_done, busy); end
    tick();
    checks++;
    if (wb_done !== 1'b1 || wb_ch !== 1'b0 || rf_wdata !== 64'h11) begin
      errors++; $display("[TB] FAIL reset_first_retire: done=%b ch=%b data=%h want 1 0 11", wb_done, wb_ch, rf_wdata);
    end
    tick();
    checks++;
    if (wb_done !== 1'b1 || wb_ch !== 1'b1 || rf_wdata !== 64'h22) begin
      errors++; $display("[TB] FAIL reset_second_retire: done=%b ch=%b data=%h want 1 1 22", wb_done, wb_ch, rf_wdata);
    end
    tick();
    checks++;
    if (wb_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_drain: done=%b busy=%b want 0 0", wb_done, busy); end
  endtask

  task automatic test_single();
    drive(1, 1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF);
    tick();
    in_valid = 2'b00;
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'hDEAD_BEEF || wb_done !== 1'b1 || wb_ch !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_retire: we=%b addr=%0d data=%h done=%b ch=%b want 1 5 deadbeef 1 1",
               rf_we, rf_waddr, rf_wdata, wb_done, wb_ch);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || wb_done !== 1'b0 || rf_waddr !== 5'd5) begin
      errors++; $display("[TB] FAIL single_after: we=%b done=%b addr=%0d want 0 0 5", rf_we, wb_done, rf_waddr);
    end
  endtask

  task automatic test_x0();
    drive(0, 1'b1, 1'b1, 5'd0, 64'd7);
    tick();
    in_valid = 2'b00;
    tick();
    checks++;
    if (wb_done !== 1'b1 || rf_we !== 1'b0 || wb_ch !== 1'b0 || rf_wdata !== 64'd7) begin
      errors++; $display("[TB] FAIL x0_suppress: done=%b we=%b ch=%b data=%h want 1 0 0 7", wb_done, rf_we, wb_ch, rf_wdata);
    end
    drive(0, 1'b1, 1'b0, 5'd3, 64'h33);
    tick();
    in_valid = 2'b00;
    tick();
    checks++;
    if (wb_done !== 1'b1 || rf_we !== 1'b0 || rf_waddr !== 5'd3) begin
      errors++; $display("[TB] FAIL nowen_retire: done=%b we=%b addr=%0d want 1 0 3", wb_done, rf_we, rf_waddr);
    end
    tick();
  endtask

  // Runs right after test_x0, whose last grant leaves channel 1 with priority.
  task automatic test_backpressure();
    int n[2], r[2], lim[2];
    logic [1:0] rdy;
    n = '{0, 0}; r = '{0, 0}; lim = '{5, 6};
    for (int cyc = 0; cyc < 40 && (r[0] < 5 || r[1] < 6); cyc++) begin
      for (int c = 0; c < 2; c++) drive(c, n[c] < lim[c], 1'b1, 5'(1 + c*8 + n[c]), dat(c, n[c]));
      #1;
      rdy = in_ready;
      if (cyc < 3) begin
        checks++;
        if (rdy[0] !== (cyc < 2)) begin errors++; $display("[TB] FAIL bp_ready cyc%0d: got %b want %b", cyc, rdy[0], cyc < 2); end
      end
      tick();
      for (int c = 0; c < 2; c++) if (n[c] < lim[c] && rdy[c]) n[c]++;
      if (wb_done) begin
        checks++;
        if (r[wb_ch] >= lim[wb_ch] || rf_wdata !== dat(int'(wb_ch), r[wb_ch])) begin
          errors++; $display("[TB] FAIL bp_order ch%0d idx%0d: got %h want %h", wb_ch, r[wb_ch], rf_wdata, dat(int'(wb_ch), r[wb_ch]));
        end
        r[wb_ch]++;
      end
    end
    in_valid = 2'b00;
    checks++;
    if (r[0] != 5 || r[1] != 6) begin errors++; $display("[TB] FAIL bp_count: got %0d/%0d want 5/6", r[0], r[1]); end
    tick();
    checks++;
    if (wb_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_extra: done=%b busy=%b want 0 0", wb_done, busy); end
  endtask

  task automatic test_round_robin();
    int n[2], r[2], j;
    logic [1:0] rdy;
    n = '{0, 0}; r = '{0, 0}; j = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int cyc = 0; cyc < 30 && j < 8; cyc++) begin
      for (int c = 0; c < 2; c++) drive(c, n[c] < 4, 1'b1, 5'(2 + c*8 + n[c]), dat(c, 16 + n[c]));
      #1;
      rdy = in_ready;
      tick();
      for (int c = 0; c < 2; c++) if (n[c] < 4 && rdy[c]) n[c]++;
      if (wb_done) begin
        checks++;
        if (wb_ch !== 1'(j % 2) || rf_wdata !== dat(int'(wb_ch), 16 + r[wb_ch])) begin
          errors++; $display("[TB] FAIL rr_seq retire%0d: ch=%b data=%h want ch=%0d data=%h",
                             j, wb_ch, rf_wdata, j % 2, dat(j % 2, 16 + r[j % 2]));
        end
        r[wb_ch]++;
        j++;
      end
    end
    in_valid = 2'b00;
    checks++;
    if (j != 8) begin errors++; $display("[TB] FAIL rr_count: got %0d want 8", j); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(0, 1'b1, 1'b1, 5'd4, 64'hC0);
    drive(1, 1'b1, 1'b1, 5'd6, 64'hD0);
    tick();
    drive(0, 1'b1, 1'b1, 5'd4, 64'hC1);
    drive(1, 1'b1, 1'b1, 5'd6, 64'hD1);
    tick();
    in_valid = 2'b00;
    reset    = 1'b1;
    tick();
    checks++;
    if (wb_done !== 1'b0 || rf_we !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_clear: done=%b we=%b busy=%b want 0 0 0", wb_done, rf_we, busy);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (wb_done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_discard cyc%0d: done=%b want 0", i, wb_done); end
    end
    drive(1, 1'b1, 1'b1, 5'd9, 64'hCAFE);
    tick();
    in_valid = 2'b00;
    tick();
    checks++;
    if (wb_done !== 1'b1 || wb_ch !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 64'hCAFE) begin
      errors++; $display("[TB] FAIL midreset_new: done=%b ch=%b we=%b addr=%0d data=%h want 1 1 1 9 cafe",
                         wb_done, wb_ch, rf_we, rf_waddr, rf_wdata);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = '0;
    in_wen   = '0;
    in_dest  = '0;
    in_data  = '0;
    test_reset();
    test_single();
    test_x0();
    test_backpressure();
    test_round_robin();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
